cb_fetch: RTL and testbench



---
 rtl/cb_fetch_if.sv | 25 ++
 rtl/cb_fetch.sv | 190 +++++++++++++++++++
 tb/tb_cb_fetch.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cb_fetch_if.sv
// Command-buffer fetch bus: RAM read port plus the segment stream to the rasterizer.
// Segment handshake: a segment transfers on a rising clk edge where seg_valid && seg_ready;
// once raised, seg_valid and seg_x0..seg_y1 stay stable until that transfer, and seg_valid
// never depends combinationally on seg_ready.
interface cb_fetch_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_q;
   logic              mem_we;
   logic              seg_valid;
   logic              seg_ready;
   logic [DATA_W-1:0] seg_x0, seg_y0, seg_x1, seg_y1;

   modport master (
      output mem_addr, mem_we, seg_valid, seg_x0, seg_y0, seg_x1, seg_y1,
      input  mem_q, seg_ready
   );

   modport slave (
      input  mem_addr, mem_we, seg_valid, seg_x0, seg_y0, seg_x1, seg_y1,
      output mem_q, seg_ready
   );
endinterface

// File: rtl/cb_fetch.sv
// Command-buffer fetch unit: reads packed (x, y) vertices and streams polyline segments.
// Optional macro CB_FETCH_CLOSE_EN adds a closing segment (V[n-1], V0) for n >= 3.
module cb_fetch #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] num_points,
   output logic              busy,
   output logic              done,
   output logic [2:0]        state_dbg,
   cb_fetch_if.master        bus
);
   typedef enum logic [2:0] {IDLE, FA, FB, FC, EMIT, FIN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, n_q, n_d, cnt_q, cnt_d, mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] x_q, x_d, prev_x_q, prev_x_d, prev_y_q, prev_y_d;
   logic [DATA_W-1:0] sx0_q, sx0_d, sy0_q, sy0_d, sx1_q, sx1_d, sy1_q, sy1_d;
   logic              valid_q, valid_d, busy_q, busy_d, done_q, done_d;
`ifdef CB_FETCH_CLOSE_EN
   logic [DATA_W-1:0] first_x_q, first_x_d, first_y_q, first_y_d;
   logic              closing_q, closing_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         n_q        <= '0;
         cnt_q      <= '0;
         mem_addr_q <= '0;
         x_q        <= '0;
         prev_x_q   <= '0;
         prev_y_q   <= '0;
         sx0_q      <= '0;
         sy0_q      <= '0;
         sx1_q      <= '0;
         sy1_q      <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef CB_FETCH_CLOSE_EN
         first_x_q  <= '0;
         first_y_q  <= '0;
         closing_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         n_q        <= n_d;
         cnt_q      <= cnt_d;
         mem_addr_q <= mem_addr_d;
         x_q        <= x_d;
         prev_x_q   <= prev_x_d;
         prev_y_q   <= prev_y_d;
         sx0_q      <= sx0_d;
         sy0_q      <= sy0_d;
         sx1_q      <= sx1_d;
         sy1_q      <= sy1_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef CB_FETCH_CLOSE_EN
         first_x_q  <= first_x_d;
         first_y_q  <= first_y_d;
         closing_q  <= closing_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      n_d        = n_q;
      cnt_d      = cnt_q;
      mem_addr_d = mem_addr_q;
      x_d        = x_q;
      prev_x_d   = prev_x_q;
      prev_y_d   = prev_y_q;
      sx0_d      = sx0_q;
      sy0_d      = sy0_q;
      sx1_d      = sx1_q;
      sy1_d      = sy1_q;
      valid_d    = valid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
`ifdef CB_FETCH_CLOSE_EN
      first_x_d  = first_x_q;
      first_y_d  = first_y_q;
      closing_d  = closing_q;
`endif
      case (state_q)
         IDLE: begin
            // done_q high means this is the completion cycle; start is ignored there.
            if (start && !done_q) begin
               busy_d = 1'b1;
               addr_d = base_addr;
               n_d    = num_points;
               cnt_d  = '0;
`ifdef CB_FETCH_CLOSE_EN
               closing_d = 1'b0;
`endif
               if (num_points < ADDR_W'(2)) begin
                  state_d = FIN;
               end else begin
                  mem_addr_d = base_addr;
                  state_d    = FA;
               end
            end
         end
         FA: begin
            mem_addr_d = addr_q + ADDR_W'(1);
            state_d    = FB;
         end
         FB: begin
            x_d     = bus.mem_q;
            state_d = FC;
         end
         FC: begin
            addr_d = addr_q + ADDR_W'(2);
            cnt_d  = cnt_q + ADDR_W'(1);
            if (cnt_q == '0) begin
               prev_x_d   = x_q;
               prev_y_d   = bus.mem_q;
`ifdef CB_FETCH_CLOSE_EN
               first_x_d  = x_q;
               first_y_d  = bus.mem_q;
`endif
               mem_addr_d = addr_q + ADDR_W'(2);
               state_d    = FA;
            end else begin
               sx0_d   = prev_x_q;
               sy0_d   = prev_y_q;
               sx1_d   = x_q;
               sy1_d   = bus.mem_q;
               valid_d = 1'b1;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (bus.seg_ready) begin
               prev_x_d = sx1_q;
               prev_y_d = sy1_q;
               valid_d  = 1'b0;
               // cnt_q counts vertices fetched so far; addr_q already points at the next x byte.
               if (cnt_q != n_q) begin
                  mem_addr_d = addr_q;
                  state_d    = FA;
               end else begin
                  state_d = FIN;
               end
`ifdef CB_FETCH_CLOSE_EN
               if (closing_q) begin
                  state_d = FIN;
               end else if (cnt_q == n_q && n_q >= ADDR_W'(3)) begin
                  closing_d = 1'b1;
                  sx0_d     = sx1_q;
                  sy0_d     = sy1_q;
                  sx1_d     = first_x_q;
                  sy1_d     = first_y_q;
                  valid_d   = 1'b1;
                  state_d   = EMIT;
               end
`endif
            end
         end
         FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign state_dbg     = state_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_we    = 1'b0;
   assign bus.seg_valid = valid_q;
   assign bus.seg_x0    = sx0_q;
   assign bus.seg_y0    = sy0_q;
   assign bus.seg_x1    = sx1_q;
   assign bus.seg_y1    = sy1_q;
endmodule

// File: tb/tb_cb_fetch.sv
// Bench for cb_fetch: RAM model, segment scoreboard built from the vertex layout rules,
// handshake stability checks and cycle-timing checks against the documented edge numbers.
module tb_cb_fetch;
   localparam int AW = 10;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] num_points = '0;
   logic          busy, done;
   logic [2:0]    state_dbg;

   cb_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   cb_fetch #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .num_points (num_points),
      .busy       (busy),
      .done       (done),
      .state_dbg  (state_dbg),
      .bus        (bus)
   );

   // ---------------- clock / RAM model ----------------
   always #5 clk = ~clk;

   logic [DW-1:0] ram [0:1023];
   always @(posedge clk) bus.mem_q <= ram[bus.mem_addr];

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   int          ready_mode = 0;
   int          stall_left = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_seg = '0;

`ifdef CB_FETCH_CLOSE_EN
   localparam bit CLOSE = 1'b1;
`else
   localparam bit CLOSE = 1'b0;
`endif

   function automatic logic [31:0] seg_now();
      return {bus.seg_x0, bus.seg_y0, bus.seg_x1, bus.seg_y1};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got event missing expected event present", name);
   endtask

   // Reference: vertex k lives at base+2k (x) and base+2k+1 (y), addresses mod 1024.
   task automatic push_expected(input logic [AW-1:0] base, input int n);
      logic [AW-1:0] a;
      logic [DW-1:0] vx[$];
      logic [DW-1:0] vy[$];
      for (int k = 0; k < n; k++) begin
         a = base + AW'(2 * k);
         vx.push_back(ram[a]);
         a = a + AW'(1);
         vy.push_back(ram[a]);
      end
      for (int k = 0; k + 1 < n; k++)
         exp_q.push_back({vx[k], vy[k], vx[k+1], vy[k+1]});
      if (CLOSE && n >= 3)
         exp_q.push_back({vx[n-1], vy[n-1], vx[0], vy[0]});
   endtask

   function automatic int seg_count(input int n);
      if (n < 2) return 0;
      return n - 1 + ((CLOSE && n >= 3) ? 1 : 0);
   endfunction

   // With seg_ready held high: vertex 1 at edge 6, one segment per 4 cycles, done one edge
   // after the last handshake (closing segment transfers on the edge right after).
   function automatic int done_edge(input int n);
      if (n < 2) return 1;
      return 6 + 4 * (n - 2) + 1 + ((CLOSE && n >= 3) ? 1 : 0) + 1;
   endfunction

   // ---------------- rasterizer ready driver ----------------
   initial begin
      bus.seg_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: bus.seg_ready = 1'b1;
            1: bus.seg_ready = ($urandom_range(0, 3) != 0);
            default: begin
               if (stall_left > 0) begin
                  bus.seg_ready = 1'b0;
                  if (bus.seg_valid) stall_left--;
               end else begin
                  bus.seg_ready = 1'b1;
               end
            end
         endcase
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         check("mem_we", bus.mem_we, 32'd0);
         if (prev_stall) begin
            check("hold_valid", bus.seg_valid, 32'd1);
            check("hold_seg", seg_now(), prev_seg);
         end
         if (bus.seg_valid && bus.seg_ready) begin
            if (exp_q.size() == 0) fail_now("extra_segment");
            else check("segment", seg_now(), exp_q.pop_front());
            got_q.push_back(seg_now());
         end
         if (done) check("done_drain", exp_q.size(), 32'd0);
         prev_stall = bus.seg_valid && !bus.seg_ready;
         prev_seg   = seg_now();
      end
   end

   // ---------------- driver task ----------------
   task automatic run_fetch(input logic [AW-1:0] base, input int n, input int mode,
                            input bit repulse, input string tag);
      int edge_n;
      int first_sv;
      bit busy_ok;
      ready_mode = mode;
      stall_left = (mode == 2) ? 5 : 0;
      got_q.delete();
      push_expected(base, n);
      @(posedge clk);
      #1;
      start      = 1'b1;
      base_addr  = base;
      num_points = AW'(n);
      @(posedge clk);
      #1;
      start      = 1'b0;
      base_addr  = ~base;
      num_points = AW'($urandom_range(0, 1023));
      edge_n     = 0;
      first_sv   = -1;
      busy_ok    = 1'b1;
      check({tag, "_busy_edge0"}, busy, 32'd1);
      while (!done && edge_n < 2000) begin
         if (repulse && edge_n == 2) begin
            start      = 1'b1;
            base_addr  = base + AW'(100);
            num_points = AW'(5);
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         edge_n++;
         if (bus.seg_valid && first_sv < 0) first_sv = edge_n;
         if (!done && !busy) busy_ok = 1'b0;
      end
      start = 1'b0;
      if (!done) begin
         fail_now({tag, "_done_timeout"});
         return;
      end
      if (mode == 0) check({tag, "_done_edge"}, edge_n, done_edge(n));
      check({tag, "_busy_at_done"}, busy, 32'd0);
      check({tag, "_busy_held"}, busy_ok, 32'd1);
      if (n < 2) check({tag, "_no_valid"}, first_sv, -1);
      else if (mode == 0) check({tag, "_first_valid_edge"}, first_sv, 32'd6);
      // start in the done cycle must be ignored
      start      = 1'b1;
      base_addr  = base + AW'(7);
      num_points = AW'(4);
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_start_in_done_ignored"}, busy, 32'd0);
      check({tag, "_done_one_cycle"}, done, 32'd0);
      check({tag, "_seg_count"}, got_q.size(), seg_count(n));
      check({tag, "_exp_empty"}, exp_q.size(), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = DW'($urandom_range(0, 255));
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 32'd0);
      check("rst_done", done, 32'd0);
      check("rst_valid", bus.seg_valid, 32'd0);
      check("rst_seg", seg_now(), 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_we", bus.mem_we, 32'd0);
      rst_n = 1'b1;

      // Triangle data, ready held high; literal segments pin the model.
      ram[0] = 8'd26; ram[1] = 8'd25; ram[2] = 8'd41;
      ram[3] = 8'd26; ram[4] = 8'd51; ram[5] = 8'd26;
      run_fetch(10'd0, 3, 0, 1'b0, "tri");
      check("tri_seg0_literal", got_q[0], 32'h1A19_291A);
      check("tri_seg1_literal", got_q[1], 32'h291A_331A);
      if (CLOSE) check("tri_close_literal", got_q[2], 32'h331A_1A19);

      // Same data, rasterizer stalls 5 cycles on the first segment.
      run_fetch(10'd0, 3, 2, 1'b0, "stall");
      check("stall_seg0_literal", got_q[0], 32'h1A19_291A);

      // Buffer wrapping from 1023 to 0.
      ram[1022] = 8'd10; ram[1023] = 8'd20; ram[0] = 8'd30; ram[1] = 8'd40;
      run_fetch(10'd1022, 2, 0, 1'b0, "wrap");
      check("wrap_seg_literal", got_q[0], 32'h0A14_1E28);

      // Degenerate counts.
      run_fetch(10'd37, 1, 0, 1'b0, "n1");
      run_fetch(10'd500, 0, 0, 1'b0, "n0");

      // start re-pulsed while busy with another base.
      run_fetch(10'd200, 4, 0, 1'b1, "repulse");

      // Reset while a segment is pending in EMIT.
      ready_mode = 2;
      stall_left = 100;
      push_expected(10'd300, 5);
      @(posedge clk);
      #1;
      start = 1'b1; base_addr = 10'd300; num_points = 10'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 50 && !bus.seg_valid; i++) begin
         @(posedge clk);
         #1;
      end
      check("abort_reached_emit", bus.seg_valid, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 32'd0);
      check("abort_done", done, 32'd0);
      check("abort_valid", bus.seg_valid, 32'd0);
      check("abort_seg", seg_now(), 32'd0);
      check("abort_mem_addr", bus.mem_addr, 32'd0);
      exp_q.delete();
      stall_left = 0;
      ready_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_fetch(10'd300, 5, 0, 1'b0, "after_abort");

      // Randomized fetches with random backpressure.
      for (int it = 0; it < 25; it++) begin
         for (int i = 0; i < 1024; i++) ram[i] = DW'($urandom_range(0, 255));
         run_fetch(AW'($urandom_range(0, 1023)), $urandom_range(0, 9),
                   $urandom_range(0, 1), 1'b0, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end
endmodule
